renkon_pool_window3: RTL and testbench

//   Producer side of the 3x3 max-pool datapath. Accepts a row-major pixel stream
//   of one square feature map and emits every stride-1 3x3 window as nine packed

---
 rtl/renkon_pool_window3.sv | 108 ++++++++++
 tb/tb_renkon_pool_window3.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/renkon_pool_window3.sv
// renkon_pool_window3: turns a row-major pixel stream into packed stride-1 3x3 windows.
module renkon_pool_window3 #(
  parameter int DWIDTH  = 16,
  parameter int MAXSIZE = 32,
  parameter int SIZEW   = $clog2(MAXSIZE + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SIZEW-1:0]    img_size,
  input  logic                pixel_en,
  input  logic [DWIDTH-1:0]   pixel_in,
  output logic                busy,
  output logic                win_valid,
  output logic                win_last,
  output logic [9*DWIDTH-1:0] win
);
  localparam int AW = MAXSIZE > 1 ? $clog2(MAXSIZE) : 1;
  localparam logic [SIZEW-1:0] ONE   = SIZEW'(1);
  localparam logic [SIZEW-1:0] TWO   = SIZEW'(2);
  localparam logic [SIZEW-1:0] THREE = SIZEW'(3);
  localparam logic [SIZEW-1:0] MAXN  = SIZEW'(MAXSIZE);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [SIZEW-1:0] n_q, n_d, row_q, row_d, col_q, col_d;
  logic [DWIDTH-1:0] sw_q [6];
  logic [DWIDTH-1:0] sw_d [6];
  logic [DWIDTH-1:0] col_px [3];
  logic [DWIDTH-1:0] lb1_mem [MAXSIZE];
  logic [DWIDTH-1:0] lb2_mem [MAXSIZE];
  logic [9*DWIDTH-1:0] win_q, win_d;
  logic win_valid_q, win_valid_d, win_last_q, win_last_d;
  logic acc, col_end, last_px, size_ok;
  logic [AW-1:0] ci;
  assign ci      = col_q[AW-1:0];
  assign acc     = state_q == RUN && pixel_en;
  assign col_end = col_q == n_q - ONE;
  assign last_px = col_end && row_q == n_q - ONE;
  assign size_ok = img_size >= THREE && img_size <= MAXN;
  assign busy      = state_q == RUN;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;
  assign win       = win_q;
  // sw_q holds the two most recent columns per window row; the incoming column completes the window
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    row_d       = row_q;
    col_d       = col_q;
    sw_d        = sw_q;
    win_d       = win_q;
    col_px[0]   = lb2_mem[ci];
    col_px[1]   = lb1_mem[ci];
    col_px[2]   = pixel_in;
    win_valid_d = acc && row_q >= TWO && col_q >= TWO;
    win_last_d  = win_valid_d && last_px;
    if (state_q == IDLE && start && size_ok) begin
      state_d = RUN;
      n_d     = img_size;
      row_d   = '0;
      col_d   = '0;
    end
    if (acc) begin
      col_d   = col_end ? '0 : col_q + ONE;
      row_d   = col_end ? row_q + ONE : row_q;
      state_d = last_px ? IDLE : RUN;
    end
    for (int r = 0; r < 3; r++) begin
      if (acc) begin
        sw_d[2*r]   = sw_q[2*r+1];
        sw_d[2*r+1] = col_px[r];
      end
      if (win_valid_d) begin
        win_d[(3*r)*DWIDTH +: DWIDTH]   = sw_q[2*r];
        win_d[(3*r+1)*DWIDTH +: DWIDTH] = sw_q[2*r+1];
        win_d[(3*r+2)*DWIDTH +: DWIDTH] = col_px[r];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      sw_q        <= '{default: '0};
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      row_q       <= row_d;
      col_q       <= col_d;
      sw_q        <= sw_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end
  // line buffers: lb1 holds the previous row, lb2 the row before it
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2_mem[ci] <= lb1_mem[ci];
      lb1_mem[ci] <= pixel_in;
    end
  end
endmodule

// File: tb/tb_renkon_pool_window3.sv
// tb_renkon_pool_window3: table vectors, directed sequences and random images against a 2D-array model.
module tb_renkon_pool_window3;
  localparam int DW = 16;
  localparam int MS = 32;
  localparam int SW = $clog2(MS + 1);
  logic clk = 1'b0;
  logic rst, start, pixel_en;
  logic [SW-1:0] img_size;
  logic [DW-1:0] pixel_in;
  logic busy, win_valid, win_last;
  logic [9*DW-1:0] win;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_run;
  int m_n, m_k;
  logic [DW-1:0] img [MS][MS];
  logic [9*DW-1:0] m_win;
  logic [9*DW-1:0] got_q [$];
  bit last_q [$];
  typedef struct {
    logic [SW-1:0] sz;
    bit            busy;
  } st_t;
  st_t tbl [6];

  always #5 clk = ~clk;

  renkon_pool_window3 #(.DWIDTH(DW), .MAXSIZE(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .img_size(img_size),
    .pixel_en(pixel_en), .pixel_in(pixel_in), .busy(busy),
    .win_valid(win_valid), .win_last(win_last), .win(win)
  );

  task automatic chk(input string nm, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [9*DW-1:0] ramp(input int base, input int n, input int r0, input int c0);
    logic [9*DW-1:0] res;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[(3*i+j)*DW +: DW] = DW'(base + (r0 + i) * n + c0 + j);
    return res;
  endfunction

  // one clock: drive inputs, advance the model from the spec's rules, then compare
  task automatic cyc(input logic s, input logic [SW-1:0] sz, input logic pe, input logic [DW-1:0] px);
    bit ev, el;
    int r, c;
    ev = 0;
    el = 0;
    start = s; img_size = sz; pixel_en = pe; pixel_in = px;
    if (m_run && pe) begin
      r = m_k / m_n;
      c = m_k % m_n;
      img[r][c] = px;
      if (r >= 2 && c >= 2) begin
        ev = 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            m_win[(3*i+j)*DW +: DW] = img[r-2+i][c-2+j];
      end
      el = ev && (m_k == m_n * m_n - 1);
      m_k++;
      if (m_k == m_n * m_n) m_run = 0;
    end else if (!m_run && s && sz >= 3 && sz <= MS) begin
      m_run = 1;
      m_n = int'(sz);
      m_k = 0;
    end
    @(posedge clk);
    #1;
    chk("busy", 144'(busy), 144'(m_run));
    chk("win_valid", 144'(win_valid), 144'(ev));
    chk("win_last", 144'(win_last), 144'(el));
    chk("win", win, m_win);
    if (win_valid) begin
      got_q.push_back(win);
      last_q.push_back(win_last);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 144'(busy), '0);
    chk("rst_win_valid", 144'(win_valid), '0);
    chk("rst_win_last", 144'(win_last), '0);
    chk("rst_win", win, '0);
    m_run = 0;
    m_win = '0;
    start = 0;
    pixel_en = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; pixel_en = 0; img_size = '0; pixel_in = '0;
    m_run = 0; m_win = '0; m_n = 3; m_k = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 144'(busy), '0);
    chk("reset_win_valid", 144'(win_valid), '0);
    chk("reset_win_last", 144'(win_last), '0);
    chk("reset_win", win, '0);
    rst = 1'b0;

    // N=4 continuous ramp
    got_q.delete(); last_q.delete();
    cyc(1, 4, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, DW'(i));
    cyc(0, 0, 0, 0);
    chk("t1_count", 144'(got_q.size()), 144'(4));
    if (got_q.size() >= 4) begin
      chk("t1_first", got_q[0], ramp(0, 4, 0, 0));
      chk("t1_fourth", got_q[3], ramp(0, 4, 1, 1));
      chk("t1_last_flag", 144'(last_q[3]), 144'(1));
      chk("t1_not_last", 144'(last_q[2]), '0);
    end

    // N=3 with gaps every other cycle
    got_q.delete(); last_q.delete();
    cyc(1, 3, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 1, DW'(i));
      cyc(0, 0, 0, 16'hdead);
    end
    chk("t2_count", 144'(got_q.size()), 144'(1));
    if (got_q.size() >= 1) begin
      chk("t2_win", got_q[0], ramp(1, 3, 0, 0));
      chk("t2_last", 144'(last_q[0]), 144'(1));
    end
    chk("t2_busy_after", 144'(busy), '0);

    // start acceptance table
    tbl[0] = '{sz: 0, busy: 0};
    tbl[1] = '{sz: 2, busy: 0};
    tbl[2] = '{sz: 3, busy: 1};
    tbl[3] = '{sz: SW'(MS), busy: 1};
    tbl[4] = '{sz: SW'(MS + 1), busy: 0};
    tbl[5] = '{sz: SW'(MS + 20), busy: 0};
    got_q.delete(); last_q.delete();
    for (int t = 0; t < 6; t++) begin
      cyc(1, tbl[t].sz, 0, 0);
      chk("tbl_busy", 144'(busy), 144'(tbl[t].busy));
      if (m_run) do_reset();
      else for (int i = 0; i < 3; i++) cyc(0, 0, 1, DW'($urandom));
    end
    chk("t3_no_windows", 144'(got_q.size()), '0);

    // N=MAXSIZE ramp with random gaps
    got_q.delete(); last_q.delete();
    cyc(1, SW'(MS), 0, 0);
    for (int i = 0; i < MS * MS; i++) begin
      if ($urandom_range(3, 0) == 0) cyc(0, 0, 0, DW'($urandom));
      cyc(0, 0, 1, DW'(i));
    end
    cyc(0, 0, 0, 0);
    chk("t3_count", 144'((MS - 2) * (MS - 2)), 144'(got_q.size()));

    // two N=5 images back to back
    got_q.delete(); last_q.delete();
    cyc(1, 5, 0, 0);
    for (int i = 0; i < 25; i++) cyc(0, 0, 1, DW'(i));
    cyc(1, 5, 0, 0);
    for (int i = 0; i < 25; i++) cyc(0, 0, 1, DW'(1000 + i));
    cyc(0, 0, 0, 0);
    chk("t4_count", 144'(got_q.size()), 144'(18));
    if (got_q.size() >= 18) begin
      chk("t4_first_last", 144'(last_q[8]), 144'(1));
      chk("t4_img1_last", got_q[8], ramp(0, 5, 2, 2));
      chk("t4_img2_first", got_q[9], ramp(1000, 5, 0, 0));
      chk("t4_img2_last", got_q[17], ramp(1000, 5, 2, 2));
    end

    // reset mid-image, then a clean N=4 with stray starts
    got_q.delete(); last_q.delete();
    cyc(1, 5, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, DW'(500 + i));
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, DW'(700 + i));
    chk("t5_none_after_rst", 144'(got_q.size()), '0);
    cyc(1, 4, 0, 0);
    for (int i = 0; i < 16; i++) cyc(i % 2 == 0, 3, 1, DW'(i));
    cyc(0, 0, 0, 0);
    chk("t5_count", 144'(got_q.size()), 144'(4));
    if (got_q.size() >= 4) chk("t5_fourth", got_q[3], ramp(0, 4, 1, 1));

    // random images, random data, gaps and stray starts
    for (int im = 0; im < 25; im++) begin
      int n;
      n = $urandom_range(8, 3);
      cyc(1, SW'(n), 0, 0);
      for (int i = 0; i < n * n; i++) begin
        if ($urandom_range(2, 0) == 0) cyc($urandom_range(1, 0) == 1, SW'($urandom_range(MS, 3)), 0, DW'($urandom));
        cyc($urandom_range(4, 0) == 0, SW'($urandom), 1, DW'($urandom));
      end
      if ($urandom_range(1, 0) == 1) cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
